// File: rtl/sound_event_arbiter_pkg.sv
// Shared types and constants for the sound event arbiter.
// Defines the FSM states, event indices and drop-count saturation.
package snd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int EV_START = 3;
  localparam int EV_KILL  = 2;
  localparam int EV_HIT   = 1;
  localparam int EV_SHOT  = 0;
  localparam int DROP_MAX = 255;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {6'b0, b};
    return (s > 9'(DROP_MAX)) ? 8'(DROP_MAX) : s[7:0];
  endfunction

endpackage

// File: rtl/sound_event_arbiter_if.sv
// Event request levels in, one-hot sound select and drop status out.
// No flow control: requests are levels; outputs are registered state.
interface sound_event_arbiter_if;
  logic [3:0] ev_req;
  logic [3:0] snd_sel;
  logic       snd_active;
  logic [1:0] cur_id;
  logic       ev_drop;
  logic [7:0] drop_cnt;

  modport master (
    output ev_req,
    input  snd_sel, snd_active, cur_id, ev_drop, drop_cnt
  );

  modport slave (
    input  ev_req,
    output snd_sel, snd_active, cur_id, ev_drop, drop_cnt
  );
endinterface

// File: rtl/sound_event_arbiter_prio_enc.sv
// Combinational 4-bit priority encoder, highest index wins.
// Zero latency; no backpressure.
module snd_prio_enc
  import snd_arb_pkg::*;
(
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       vld
);
  always_comb begin
    idx = 2'(EV_SHOT);
    vld = 1'b1;
    if      (req[EV_START]) idx = 2'(EV_START);
    else if (req[EV_KILL])  idx = 2'(EV_KILL);
    else if (req[EV_HIT])   idx = 2'(EV_HIT);
    else if (req[EV_SHOT])  idx = 2'(EV_SHOT);
    else                    vld = 1'b0;
  end
endmodule

// File: rtl/sound_event_arbiter.sv
// Latches rising edges of four event levels and plays them one at a time, highest first;
// an event raised from idle is audible two cycles later. SND_ARB_PREEMPT_EN enables preemption.
module sound_event_arbiter
  import snd_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 5_000_000,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sound_event_arbiter_if.slave bus
);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       prev, pending, pending_n;
  logic [3:0]       snd_sel, sel_n;
  logic [1:0]       cur_id, cur_n;
  logic             snd_active, act_n;
  logic             ev_drop, drop_n;
  logic [7:0]       drop_cnt, drop_cnt_n;

  logic [3:0] rise, grant_mask, drop_bits;
  logic [1:0] g_idx;
  logic       g_vld, grant_ok, preempt;
  logic [2:0] n_drop;

  snd_prio_enc u_enc (.req(pending), .idx(g_idx), .vld(g_vld));

  assign rise = bus.ev_req & ~prev;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sel_n      = snd_sel;
    cur_n      = cur_id;
    act_n      = snd_active;
    grant_ok   = 1'b0;
    preempt    = 1'b0;
    grant_mask = 4'b0000;
    case (state)
      ST_IDLE: grant_ok = 1'b1;
      ST_PLAY: begin
        if (cnt == '0) begin
          sel_n = 4'b0000;
          act_n = 1'b0;
          if (GAP_CYCLES != 0) begin
            state_n = ST_GAP;
            cnt_n   = GAP_LOAD;
          end else begin
            state_n  = ST_IDLE;
            grant_ok = 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
`ifdef SND_ARB_PREEMPT_EN
          // Only a strictly higher-priority event may cut the current sound short.
          if (g_vld && (g_idx > cur_id)) begin
            grant_ok = 1'b1;
            preempt  = 1'b1;
          end
`endif
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_n  = ST_IDLE;
          grant_ok = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (grant_ok && g_vld) begin
      state_n    = ST_PLAY;
      cnt_n      = HOLD_LOAD;
      sel_n      = 4'(4'b0001 << g_idx);
      cur_n      = g_idx;
      act_n      = 1'b1;
      grant_mask = 4'(4'b0001 << g_idx);
    end

    // A rise on the bit being granted this cycle re-arms it rather than dropping.
    pending_n  = (pending & ~grant_mask) | rise;
    drop_bits  = rise & pending & ~grant_mask;
    n_drop     = {2'b0, drop_bits[0]} + {2'b0, drop_bits[1]} + {2'b0, drop_bits[2]}
               + {2'b0, drop_bits[3]} + {2'b0, preempt};
    drop_n     = (n_drop != 3'd0);
    drop_cnt_n = sat_add(drop_cnt, n_drop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      prev       <= 4'b1111;
      pending    <= 4'b0000;
      snd_sel    <= 4'b0000;
      cur_id     <= 2'd0;
      snd_active <= 1'b0;
      ev_drop    <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      prev       <= bus.ev_req;
      pending    <= pending_n;
      snd_sel    <= sel_n;
      cur_id     <= cur_n;
      snd_active <= act_n;
      ev_drop    <= drop_n;
      drop_cnt   <= drop_cnt_n;
    end
  end

  assign bus.snd_sel    = snd_sel;
  assign bus.snd_active = snd_active;
  assign bus.cur_id     = cur_id;
  assign bus.ev_drop    = ev_drop;
  assign bus.drop_cnt   = drop_cnt;
endmodule

// File: tb/tb_sound_event_arbiter.sv
// Directed bench for sound_event_arbiter with a queue-free behavioural model
// compared every cycle, plus literal checks at hand-computed cycles.
module tb_sound_event_arbiter;
  localparam int HOLD = 8;
  localparam int GAP  = 2;
`ifdef SND_ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  sound_event_arbiter_if bus();
  sound_event_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;
  bit mon_en = 1'b0;
  int drop_pulses = 0;
  int sel2_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: remaining play/gap cycles and a pending flag per event.
  logic [3:0] m_prev = 4'b1111;
  bit         m_pend [4];
  int         m_play = 0, m_gap = 0, m_cur = 0, m_cnt = 0;
  logic [3:0] m_sel = 4'b0000;
  bit         m_drop = 1'b0;

  function automatic int highest_pending();
    for (int i = 3; i >= 0; i--) if (m_pend[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_prev = 4'b1111; m_play = 0; m_gap = 0; m_cur = 0; m_cnt = 0;
      m_sel = 4'b0000; m_drop = 1'b0;
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    end else begin
      automatic logic [3:0] ev = bus.ev_req;
      automatic logic [3:0] rs = ev & ~m_prev;
      automatic int drops = 0;
      automatic int gbit = -1;
      automatic bit can = 1'b0;
      m_prev = ev;
      if (m_play > 0) begin
        if (PRE && m_play > 1 && highest_pending() > m_cur) begin
          gbit = highest_pending();
          drops++;
        end else if (m_play > 1) m_play--;
        else begin
          m_play = 0; m_sel = 4'b0000;
          if (GAP > 0) m_gap = GAP; else can = 1'b1;
        end
      end else if (m_gap > 0) begin
        if (m_gap > 1) m_gap--; else begin m_gap = 0; can = 1'b1; end
      end else can = 1'b1;
      if (can) gbit = highest_pending();
      if (gbit >= 0) begin
        m_cur = gbit; m_sel = 4'(1 << gbit); m_play = HOLD; m_pend[gbit] = 1'b0;
      end
      for (int b = 0; b < 4; b++)
        if (rs[b]) begin
          if (m_pend[b]) drops++;
          m_pend[b] = 1'b1;
        end
      m_drop = (drops > 0);
      m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      automatic logic [3:0] e_sel = reset_n ? m_sel : 4'b0000;
      automatic logic       e_act = reset_n ? (m_sel != 4'b0000) : 1'b0;
      automatic logic [1:0] e_cur = reset_n ? 2'(m_cur) : 2'd0;
      automatic logic       e_drp = reset_n ? m_drop : 1'b0;
      automatic logic [7:0] e_cnt = reset_n ? 8'(m_cnt) : 8'd0;
      checks++;
      if (bus.snd_sel !== e_sel || bus.snd_active !== e_act || bus.cur_id !== e_cur ||
          bus.ev_drop !== e_drp || bus.drop_cnt !== e_cnt) begin
        errors++;
        $display("FAIL model t=%0t got sel=%b act=%b cur=%0d drop=%b cnt=%0d want sel=%b act=%b cur=%0d drop=%b cnt=%0d",
                 $time, bus.snd_sel, bus.snd_active, bus.cur_id, bus.ev_drop, bus.drop_cnt,
                 e_sel, e_act, e_cur, e_drp, e_cnt);
      end
      if (bus.ev_drop === 1'b1) drop_pulses++;
      if (bus.snd_sel === 4'b0100) sel2_cycles++;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < base + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sel_at(input int n, input logic [3:0] exp, input string name);
    goto(n);
    @(negedge clk);
    chk(name, {4'b0, bus.snd_sel}, {4'b0, exp});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.ev_req = 4'b0000;
    #1;
    chk("rst_sel", {4'b0, bus.snd_sel}, 8'd0);
    chk("rst_act", {7'b0, bus.snd_active}, 8'd0);
    chk("rst_cur", {6'b0, bus.cur_id}, 8'd0);
    chk("rst_cnt", bus.drop_cnt, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    drop_pulses = 0;
    sel2_cycles = 0;
    base = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ev_req = 4'b0000;

    // Single event
    do_reset();
    goto(10); bus.ev_req = 4'b0001;
    goto(11); bus.ev_req = 4'b0000;
    sel_at(11, 4'b0000, "single_pre");
    sel_at(12, 4'b0001, "single_start");
    chk("single_act", {7'b0, bus.snd_active}, 8'd1);
    sel_at(19, 4'b0001, "single_end");
    sel_at(20, 4'b0000, "single_gap0");
    sel_at(21, 4'b0000, "single_gap1");
    sel_at(22, 4'b0000, "single_idle");
    chk("single_drops", bus.drop_cnt, 8'd0);

    // Simultaneous events
    do_reset();
    goto(10); bus.ev_req = 4'b1010;
    goto(11); bus.ev_req = 4'b0000;
    sel_at(12, 4'b1000, "simul_a_start");
    sel_at(19, 4'b1000, "simul_a_end");
    sel_at(20, 4'b0000, "simul_gap");
    sel_at(22, 4'b0010, "simul_b_start");
    sel_at(29, 4'b0010, "simul_b_end");
    sel_at(30, 4'b0000, "simul_b_done");
    chk("simul_cur", {6'b0, bus.cur_id}, 8'd1);

    // Redundant rise while pending
    do_reset();
    goto(10); bus.ev_req = 4'b1000;
    goto(11); bus.ev_req = 4'b0000;
    goto(12); bus.ev_req = 4'b0100;
    goto(13); bus.ev_req = 4'b0000;
    goto(14); bus.ev_req = 4'b0100;
    goto(15); bus.ev_req = 4'b0000;
    @(negedge clk);
    chk("drop_pulse", {7'b0, bus.ev_drop}, 8'd1);
    sel_at(22, 4'b0100, "drop_play");
    goto(34); @(negedge clk);
    chk("drop_cnt", bus.drop_cnt, 8'd1);
    chk("drop_pulses", 8'(drop_pulses), 8'd1);
    chk("drop_play_len", 8'(sel2_cycles), 8'd8);

    // Preemption behaviour
    do_reset();
    goto(10); bus.ev_req = 4'b0001;
    goto(11); bus.ev_req = 4'b0000;
    goto(14); bus.ev_req = 4'b0100;
    goto(15); bus.ev_req = 4'b0000;
`ifdef SND_ARB_PREEMPT_EN
    sel_at(15, 4'b0001, "pre_still_low");
    sel_at(16, 4'b0100, "pre_switch");
    sel_at(23, 4'b0100, "pre_hold_end");
    sel_at(24, 4'b0000, "pre_gap");
    chk("pre_drop_cnt", bus.drop_cnt, 8'd1);
`else
    sel_at(19, 4'b0001, "nopre_full");
    sel_at(20, 4'b0000, "nopre_gap");
    sel_at(22, 4'b0100, "nopre_next");
    sel_at(29, 4'b0100, "nopre_next_end");
    chk("nopre_drop_cnt", bus.drop_cnt, 8'd0);
`endif

    // Reset mid-play with the input held high across release
    do_reset();
    goto(10); bus.ev_req = 4'b0001;
    goto(11); bus.ev_req = 4'b0000;
    sel_at(14, 4'b0001, "rst_playing");
    goto(15);
    reset_n = 1'b0;
    bus.ev_req = 4'b0001;
    #1;
    chk("rst_async_sel", {4'b0, bus.snd_sel}, 8'd0);
    chk("rst_async_act", {7'b0, bus.snd_active}, 8'd0);
    goto(17); reset_n = 1'b1;
    sel_at(22, 4'b0000, "rst_no_resume");
    goto(30); bus.ev_req = 4'b0000;
    sel_at(36, 4'b0000, "rst_no_pending");

    // Saturation: bit0 starved behind repeatedly re-armed bit3
    do_reset();
    for (int i = 0; i < 300; i++) begin
      goto(10 + 2 * i);     bus.ev_req = 4'b1001;
      goto(10 + 2 * i + 1); bus.ev_req = 4'b0000;
    end
    goto(620); @(negedge clk);
    chk("sat_cnt", bus.drop_cnt, 8'd255);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sound_event_arbiter.md
SOUND_EVENT_ARBITER -- requirements
Module: sound_event_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, 5_000_000, clk cycles one sound select is held (>=1).
REQ-002 Parameter: GAP_CYCLES, 500_000, silent clk cycles between consecutive sounds (>=0).
REQ-003 Port: clk  in  1  system clock; all state on rising edge.
REQ-004 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: ev_req  in  [3:0]  debounced, clk-synchronous event levels; bit3 start/reset (highest priority), bit2 enemy killed, bit1 player hit, bit0 shot/move (lowest priority).
REQ-006 Port: snd_sel  out  [3:0]  one-hot select to sound generator; all-zero = silence.
REQ-007 Port: snd_active  out  1  high while snd_sel is nonzero.
REQ-008 Port: cur_id  out  [1:0]  index of the playing event; holds its last value when idle.
REQ-009 Port: ev_drop  out  1  one-cycle pulse per lost event.
REQ-010 Port: drop_cnt  out  [7:0]  saturating count of lost events.

Function
REQ-011 The rising-edge detector shall compare ev_req with a registered copy; rise = ev_req & ~prev.
REQ-012 A rise in cycle N shall set the matching sticky pending bit, visible in N+1.
REQ-013 The FSM shall have the states IDLE, PLAY and GAP.
REQ-014 IDLE with any pending bit: grant the highest-index bit, clear it, load the hold counter with HOLD_CYCLES-1, go to PLAY; snd_sel, cur_id and snd_active are registered, so an event raised in N from IDLE is audible in N+2.
REQ-015 PLAY shall drive the one-hot snd_sel for exactly HOLD_CYCLES cycles.
REQ-016 When the PLAY counter reaches 0, the FSM shall go to GAP loaded with GAP_CYCLES-1, or directly to IDLE when GAP_CYCLES=0.
REQ-017 GAP shall drive snd_sel=0 for GAP_CYCLES cycles, then go to IDLE.
REQ-018 A rise on a bit already pending shall pulse ev_drop and increment drop_cnt, saturating at 255; the pending bit stays set.
REQ-019 A rise on a bit in the same cycle that bit is granted is not a drop: the grant clears the old request and the new rise re-sets pending.
REQ-020 Simultaneous rises shall all be latched; they are served in priority order, each followed by its gap.
REQ-021 Events arriving during PLAY or GAP shall only set pending; apart from the REQ-027 preemption case, the current sound finishes unaffected.

Reset
REQ-022 While reset_n is low, the following shall hold asynchronously: snd_sel=0, snd_active=0, cur_id=0, ev_drop=0, drop_cnt=0, pending=0, counters=0, state=IDLE.
REQ-023 The ev_req history register shall reset to 4'b1111, so inputs held high across reset release generate no event.
REQ-024 Reset asserted mid-PLAY shall silence output at once; the interrupted sound is not resumed.

Configuration
REQ-025 Macro SND_ARB_PREEMPT_EN shall select preemption.
REQ-026 Without SND_ARB_PREEMPT_EN, a PLAY always runs its full HOLD_CYCLES.
REQ-027 With SND_ARB_PREEMPT_EN, a pending bit of higher index than cur_id during PLAY shall cause a direct PLAY-to-PLAY switch, with no gap, to that event on the next cycle.
REQ-028 On preemption, the new event's pending bit is cleared, the counter reloads to HOLD_CYCLES-1, and the aborted sound counts as a drop: ev_drop pulses and drop_cnt increments.
REQ-029 GAP is never preempted.

Structure
REQ-030 Package snd_arb_pkg shall hold the state enumeration, event index constants (EV_START=3, EV_KILL=2, EV_HIT=1, EV_SHOT=0) and DROP_MAX=255.
REQ-031 Sub-module snd_prio_enc shall be the one natural split: a combinational 4-bit priority encoder returning the index and a valid flag.

Verification
Bench parameters: HOLD_CYCLES=8, GAP_CYCLES=2.
REQ-032 Single event: ev_req[0] pulse at cycle 10 -> snd_sel=0001 during cycles 12-19, 0000 during 20-21, IDLE at 22, drop_cnt=0.
REQ-033 Simultaneous events: ev_req=1010 for one cycle at cycle 10 -> 1000 during 12-19, gap 20-21, 0010 during 22-29, cur_id=1 at end.
REQ-034 Drop: two ev_req[2] pulses while bit2 is pending behind a playing bit3 -> exactly one ev_drop pulse, drop_cnt=1, bit2 played once.
REQ-035 Preemption: ev_req[0] playing, ev_req[2] rise at 3rd play cycle -> with macro, 0100 begins two cycles later for 8 cycles and drop_cnt=1; without macro, 0001 completes 8 cycles, gap, then 0100, drop_cnt=0.
REQ-036 Reset: reset_n low at 4th play cycle -> snd_sel=0 in that cycle; ev_req=0001 held through release -> no sound and pending=0 after release.
REQ-037 Saturation: 300 redundant rises on a pending bit -> drop_cnt=255, no wrap.
